// File: rtl/mac_ctrl_if.sv
// Operand stream, group-MAC and result handshake bundle of the MAC job sequencer.
interface mac_ctrl_if #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int CNT_WIDTH = 10
);
  localparam int RES_W = IMG_WIDTH + KER_WIDTH + 1;

  logic                                start;
  logic [CNT_WIDTH-1:0]                cfg_steps;
  logic                                busy;
  logic [GROUP_NB-1:0][IMG_WIDTH-1:0]  str_img;
  logic [GROUP_NB-1:0][KER_WIDTH-1:0]  str_ker;
  logic                                str_val;
  logic                                str_rdy;
  logic [GROUP_NB-1:0][IMG_WIDTH-1:0]  mac_img;
  logic [GROUP_NB-1:0][KER_WIDTH-1:0]  mac_ker;
  logic                                mac_val;
  logic                                mac_clr;
  logic [GROUP_NB-1:0][RES_W-1:0]      mac_result;
  logic [GROUP_NB-1:0][RES_W-1:0]      res_data;
  logic                                res_val;
  logic                                res_rdy;

  modport master (
    input  start, cfg_steps, str_img, str_ker, str_val, mac_result, res_rdy,
    output busy, str_rdy, mac_img, mac_ker, mac_val, mac_clr, res_data, res_val
  );

  modport slave (
    output start, cfg_steps, str_img, str_ker, str_val, mac_result, res_rdy,
    input  busy, str_rdy, mac_img, mac_ker, mac_val, mac_clr, res_data, res_val
  );
endinterface

// File: rtl/mac_ctrl.sv
// Job sequencer for the group MAC: clear, feed cfg_steps beats, drain the MAC
// pipeline, then hold the captured lane results until downstream takes them.
module mac_ctrl_lane #(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int RES_W     = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_i,
  input  logic                 cap_i,
  input  logic [IMG_WIDTH-1:0] img_i,
  input  logic [KER_WIDTH-1:0] ker_i,
  input  logic [RES_W-1:0]     res_i,
  output logic [IMG_WIDTH-1:0] img_o,
  output logic [KER_WIDTH-1:0] ker_o,
  output logic [RES_W-1:0]     res_o
);
  logic [IMG_WIDTH-1:0] img_q;
  logic [KER_WIDTH-1:0] ker_q;
  logic [RES_W-1:0]     res_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      img_q <= '0;
      ker_q <= '0;
      res_q <= '0;
    end else begin
      if (ld_i) begin
        img_q <= img_i;
        ker_q <= ker_i;
      end
      if (cap_i) res_q <= res_i;
    end
  end

  assign img_o = img_q;
  assign ker_o = ker_q;
  assign res_o = res_q;
endmodule

module mac_ctrl #(
  parameter int GROUP_NB    = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int KER_WIDTH   = 16,
  parameter int CNT_WIDTH   = 10,
  parameter int MAC_LATENCY = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mac_ctrl_if.master    bus
);
  localparam int RES_W = IMG_WIDTH + KER_WIDTH + 1;
  localparam int DW    = $clog2(MAC_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] step_q, step_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 mval_q, mval_d;
  logic                 str_rdy, fire, cap;

  logic [GROUP_NB-1:0][IMG_WIDTH-1:0] img_q;
  logic [GROUP_NB-1:0][KER_WIDTH-1:0] ker_q;
  logic [GROUP_NB-1:0][RES_W-1:0]     res_q;

  assign str_rdy = (state_q == S_RUN);
  assign fire    = bus.str_val & str_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      drain_q <= '0;
      mval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      mval_q  <= mval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    mval_d  = 1'b0;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.cfg_steps != '0)) begin
          step_d  = bus.cfg_steps;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (fire) begin
          mval_d = 1'b1;
          step_d = step_q - 1'b1;
          // Last beat: start counting out the MAC pipeline behind it.
          if (step_q == CNT_WIDTH'(1)) begin
            drain_d = DW'(MAC_LATENCY);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          cap     = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.res_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < GROUP_NB; g++) begin : g_lane
    mac_ctrl_lane #(
      .IMG_WIDTH (IMG_WIDTH),
      .KER_WIDTH (KER_WIDTH),
      .RES_W     (RES_W)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ld_i   (fire),
      .cap_i  (cap),
      .img_i  (bus.str_img[g]),
      .ker_i  (bus.str_ker[g]),
      .res_i  (bus.mac_result[g]),
      .img_o  (img_q[g]),
      .ker_o  (ker_q[g]),
      .res_o  (res_q[g])
    );
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.str_rdy  = str_rdy;
  assign bus.mac_clr  = (state_q == S_CLEAR);
  assign bus.mac_val  = mval_q;
  assign bus.mac_img  = img_q;
  assign bus.mac_ker  = ker_q;
  assign bus.res_val  = (state_q == S_HOLD);
  assign bus.res_data = res_q;
endmodule
